// File: rtl/wts_channel_pkg.sv
// ---------------------------------------------------------------------------
// wts_channel_pkg
// Shared definitions for the wave-table channel bank:
//   env_state_e  - envelope phase encoding (IDLE=0 .. RELEASE=4)
//   key_event_e  - the single key event applied to a channel in one service
//   level format - 25-bit envelope level, 9 integer bits . 16 fraction bits
//   LFSR         - seed and tap positions of the shared noise generator
//   waveMask()   - address mask for a given wave-length code
// ---------------------------------------------------------------------------
package wts_channel_pkg;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_e;

  typedef enum logic [1:0] {
    KEY_NONE    = 2'd0,
    KEY_OFF     = 2'd1,
    KEY_ON      = 2'd2,
    KEY_RELEASE = 2'd3
  } key_event_e;

  localparam int ENV_MAX = 256;
  localparam int FRAC_W  = 16;
  localparam int LEVEL_W = 25;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(ENV_MAX) << FRAC_W;

  localparam int LFSR_W = 17;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 17'h00001;
  localparam int LFSR_TAP_HI = 17;
  localparam int LFSR_TAP_LO = 14;

  // Wave length code 0..3 selects 32/16/8/4 samples
  function automatic logic [4:0] waveMask(input logic [1:0] waveLength);
    return 5'd31 >> waveLength;
  endfunction

endpackage

// File: rtl/wts_envelope_step.sv
// ---------------------------------------------------------------------------
// wts_envelope_step
// Purely combinational ADSR step for one channel service.
// Inputs : state_i/level_i (current channel envelope), key_i (the key event
//          already resolved by priority), ar_i/dr_i/sr_i/rr_i (rates in
//          1/65536 level per service), sl_i (integer sustain level).
// Outputs: state_o/level_o, the channel envelope after this service.
// A key event that is acted on replaces the rate step for that service.
// ---------------------------------------------------------------------------
module wts_envelope_step
  import wts_channel_pkg::*;
(
  input  env_state_e         state_i,
  input  logic [LEVEL_W-1:0] level_i,
  input  key_event_e         key_i,
  input  logic [15:0]        ar_i,
  input  logic [15:0]        dr_i,
  input  logic [15:0]        sr_i,
  input  logic [15:0]        rr_i,
  input  logic [7:0]         sl_i,
  output env_state_e         state_o,
  output logic [LEVEL_W-1:0] level_o
);

  logic [LEVEL_W:0]   attackSum;
  logic [LEVEL_W-1:0] sustainLevel;
  logic [LEVEL_W-1:0] rateDr;
  logic [LEVEL_W-1:0] rateSr;
  logic [LEVEL_W-1:0] rateRr;
  logic               releaseAccepted;

  // One extra bit on the attack sum so overshooting 256.0 is never lost
  assign attackSum    = {1'b0, level_i} + (LEVEL_W+1)'(ar_i);
  assign sustainLevel = {1'b0, sl_i, 16'h0000};
  assign rateDr       = LEVEL_W'(dr_i);
  assign rateSr       = LEVEL_W'(sr_i);
  assign rateRr       = LEVEL_W'(rr_i);

  // A release in IDLE or RELEASE is treated as if it never happened
  assign releaseAccepted = (key_i == KEY_RELEASE) &&
                           (state_i inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN});

  // Key events first, otherwise the rate step of the current phase.
  // Subtractions compare the rate against the level before subtracting so
  // the unsigned result never wraps.
  always_comb begin
    state_o = state_i;
    level_o = level_i;
    if (key_i == KEY_OFF) begin
      state_o = ENV_IDLE;
      level_o = '0;
    end else if (key_i == KEY_ON) begin
      state_o = ENV_ATTACK;
      level_o = '0;
    end else if (releaseAccepted) begin
      state_o = ENV_RELEASE;
    end else begin
      case (state_i)
        ENV_IDLE: begin
          level_o = '0;
        end
        ENV_ATTACK: begin
          if (attackSum >= {1'b0, LEVEL_MAX}) begin
            level_o = LEVEL_MAX;
            state_o = ENV_DECAY;
          end else begin
            level_o = attackSum[LEVEL_W-1:0];
          end
        end
        ENV_DECAY: begin
          if ((rateDr >= level_i) || ((level_i - rateDr) <= sustainLevel)) begin
            level_o = sustainLevel;
            state_o = ENV_SUSTAIN;
          end else begin
            level_o = level_i - rateDr;
          end
        end
        ENV_SUSTAIN: begin
          level_o = (rateSr >= level_i) ? '0 : (level_i - rateSr);
        end
        ENV_RELEASE: begin
          if (rateRr >= level_i) begin
            level_o = '0;
            state_o = ENV_IDLE;
          end else begin
            level_o = level_i - rateRr;
          end
        end
        default: begin
          level_o = '0;
          state_o = ENV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/wts_channel_bank.sv
// ---------------------------------------------------------------------------
// wts_channel_bank
// Time-multiplexed bank of CHANNELS wave-table channels. One channel (slot)
// is serviced per active pulse using the registers the register file
// presents for that slot; per-channel state lives in arrays.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   active              - one-clk service pulse
//   key_on/_release/_off- per-channel key pulses, held as sticky pending bits
//   slot                - channel whose reg_* must be presented
//   reg_*               - serviced channel's rates, sustain level, wave
//                         length, tone and noise periods, noise enable
//   out_valid/out_ch    - one-clk pulse after a service and its channel
//   envelope            - integer envelope 0..256, noise gated
//   sram_a              - {out_ch, masked wave address}
// ---------------------------------------------------------------------------
module wts_channel_bank
  import wts_channel_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CH_W     = $clog2(CHANNELS),
  parameter int FREQ_W   = 12,
  parameter int NOISE_W  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                active,
  input  logic [CHANNELS-1:0] key_on,
  input  logic [CHANNELS-1:0] key_release,
  input  logic [CHANNELS-1:0] key_off,
  output logic [CH_W-1:0]     slot,
  input  logic                reg_noise_enable,
  input  logic [15:0]         reg_ar,
  input  logic [15:0]         reg_dr,
  input  logic [15:0]         reg_sr,
  input  logic [15:0]         reg_rr,
  input  logic [7:0]          reg_sl,
  input  logic [1:0]          reg_wave_length,
  input  logic [FREQ_W-1:0]   reg_frequency_count,
  input  logic [NOISE_W-1:0]  reg_noise_frequency_count,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic [8:0]          envelope,
  output logic [CH_W+4:0]     sram_a
);

  env_state_e          envState_q [CHANNELS];
  logic [LEVEL_W-1:0]  level_q    [CHANNELS];
  logic [FREQ_W-1:0]   toneCnt_q  [CHANNELS];
  logic [4:0]          addr_q     [CHANNELS];
  logic [NOISE_W-1:0]  noiseCnt_q [CHANNELS];
  logic [CHANNELS-1:0] noiseBit_q;
  logic [CHANNELS-1:0] pendOn_q, pendOff_q, pendRel_q;
  logic [CHANNELS-1:0] pendOn_d, pendOff_d, pendRel_d;
  logic [CH_W-1:0]     slot_q;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;

  logic                outValid_q;
  logic [CH_W-1:0]     outCh_q;
  logic [8:0]          envelope_q;
  logic [CH_W+4:0]     sramA_q;

  logic [CHANNELS-1:0] slotOneHot;
  logic                svcOn, svcOff, svcRel;
  key_event_e          keyEvent;
  env_state_e          state_d;
  logic [LEVEL_W-1:0]  level_d;
  logic [FREQ_W-1:0]   toneCnt_d;
  logic [4:0]          addr_d;
  logic [4:0]          addrMask;
  logic [NOISE_W-1:0]  noiseCnt_d;
  logic                noiseBit_d;
  logic [8:0]          envelope_d;

  assign slotOneHot = CHANNELS'(1) << slot_q;

  // Keys of this very cycle count for the serviced channel, so a pulse
  // coinciding with its service is applied rather than lost
  assign svcOn  = pendOn_q[slot_q]  | key_on[slot_q];
  assign svcOff = pendOff_q[slot_q] | key_off[slot_q];
  assign svcRel = pendRel_q[slot_q] | key_release[slot_q];

  always_comb begin
    keyEvent = KEY_NONE;
    if (svcOff) begin
      keyEvent = KEY_OFF;
    end else if (svcOn) begin
      keyEvent = KEY_ON;
    end else if (svcRel) begin
      keyEvent = KEY_RELEASE;
    end
  end

  // Sticky pending keys; the serviced channel's bits are consumed
  always_comb begin
    pendOn_d  = pendOn_q  | key_on;
    pendOff_d = pendOff_q | key_off;
    pendRel_d = pendRel_q | key_release;
    if (active) begin
      pendOn_d  = pendOn_d  & ~slotOneHot;
      pendOff_d = pendOff_d & ~slotOneHot;
      pendRel_d = pendRel_d & ~slotOneHot;
    end
  end

  wts_envelope_step uEnvStep (
    .state_i (envState_q[slot_q]),
    .level_i (level_q[slot_q]),
    .key_i   (keyEvent),
    .ar_i    (reg_ar),
    .dr_i    (reg_dr),
    .sr_i    (reg_sr),
    .rr_i    (reg_rr),
    .sl_i    (reg_sl),
    .state_o (state_d),
    .level_o (level_d)
  );

  // Tone counter and wave address; key_on restarts the wave, IDLE freezes it
  always_comb begin
    addrMask  = waveMask(reg_wave_length);
    toneCnt_d = toneCnt_q[slot_q];
    addr_d    = addr_q[slot_q];
    if (keyEvent == KEY_ON) begin
      toneCnt_d = reg_frequency_count;
      addr_d    = '0;
    end else if (envState_q[slot_q] != ENV_IDLE) begin
      if (toneCnt_q[slot_q] == '0) begin
        toneCnt_d = reg_frequency_count;
        addr_d    = (addr_q[slot_q] + 5'd1) & addrMask;
      end else begin
        toneCnt_d = toneCnt_q[slot_q] - FREQ_W'(1);
      end
    end
  end

  // Noise counter runs on every service; a reload samples the shared LFSR
  always_comb begin
    noiseCnt_d = noiseCnt_q[slot_q];
    noiseBit_d = noiseBit_q[slot_q];
    if (noiseCnt_q[slot_q] == '0) begin
      noiseCnt_d = reg_noise_frequency_count;
      noiseBit_d = lfsr_q[0];
    end else begin
      noiseCnt_d = noiseCnt_q[slot_q] - NOISE_W'(1);
    end
  end

  assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI-1] ^ lfsr_q[LFSR_TAP_LO-1]};

  assign envelope_d = (reg_noise_enable && !noiseBit_d) ? 9'd0
                                                        : level_d[LEVEL_W-1:FRAC_W];

  // All state updates happen only for the serviced channel on active
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q     <= '0;
      lfsr_q     <= LFSR_SEED;
      pendOn_q   <= '0;
      pendOff_q  <= '0;
      pendRel_q  <= '0;
      noiseBit_q <= '0;
      outValid_q <= 1'b0;
      outCh_q    <= '0;
      envelope_q <= '0;
      sramA_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        envState_q[i] <= ENV_IDLE;
        level_q[i]    <= '0;
        toneCnt_q[i]  <= '0;
        addr_q[i]     <= '0;
        noiseCnt_q[i] <= '0;
      end
    end else begin
      outValid_q <= active;
      pendOn_q   <= pendOn_d;
      pendOff_q  <= pendOff_d;
      pendRel_q  <= pendRel_d;
      if (active) begin
        slot_q                 <= slot_q + CH_W'(1);
        lfsr_q                 <= lfsr_d;
        envState_q[slot_q]     <= state_d;
        level_q[slot_q]        <= level_d;
        toneCnt_q[slot_q]      <= toneCnt_d;
        addr_q[slot_q]         <= addr_d;
        noiseCnt_q[slot_q]     <= noiseCnt_d;
        noiseBit_q[slot_q]     <= noiseBit_d;
        outCh_q                <= slot_q;
        envelope_q             <= envelope_d;
        sramA_q                <= {slot_q, addr_d & addrMask};
      end
    end
  end

  assign slot      = slot_q;
  assign out_valid = outValid_q;
  assign out_ch    = outCh_q;
  assign envelope  = envelope_q;
  assign sram_a    = sramA_q;

endmodule
